// File: rtl/apb_pkg.sv
// Shared APB definitions for the slave-side responder: bus widths and the
// transfer phase type.
package apb_pkg;

  localparam int APB_DATA_W  = 32;
  localparam int APB_ADDR_W  = 32;
  localparam int APB_NUM_SEL = 4;

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    ACCESS
  } apb_phase_e;

endpackage

// File: rtl/apb_slave_modport_if.sv
// APB bus signal set shared between a master and the slave responder.
interface apb_slave_modport_if;
  import apb_pkg::*;

  logic [APB_NUM_SEL-1:0] PSEL;
  logic                   PENABLE;
  logic                   PWRITE;
  logic [APB_ADDR_W-1:0]  PADDR;
  logic [APB_DATA_W-1:0]  PWDATA;
  logic [APB_DATA_W-1:0]  PRDATA;
  logic                   PREADY;

  modport master (
    output PSEL, PENABLE, PWRITE, PADDR, PWDATA,
    input  PRDATA, PREADY
  );

  modport slave (
    input  PSEL, PENABLE, PWRITE, PADDR, PWDATA,
    output PRDATA, PREADY
  );

endinterface

// File: rtl/apb_reg_bank.sv
// One bank of DEPTH x 32-bit registers: single write port, combinational read
// of the same word index.
module apb_reg_bank
  import apb_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic                     CLK,
  input  logic                     PRESET,
  input  logic                     i_we,
  input  logic [$clog2(DEPTH)-1:0] i_idx,
  input  logic [APB_DATA_W-1:0]    i_wdata,
  output logic [APB_DATA_W-1:0]    o_rdata
);

  logic [APB_DATA_W-1:0] r_mem [DEPTH];

  // NOTE: the register contents are architecturally visible after reset
  // (reads must return 0), so every word is reset rather than left undefined.
  always_ff @(posedge CLK) begin
    if (PRESET) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else if (i_we) begin
      r_mem[i_idx] <= i_wdata;
    end
  end

  assign o_rdata = r_mem[i_idx];

endmodule

// File: rtl/apb_slave_modport.sv
// APB slave responder: phase decode, wait-state counter, one-hot bank select
// and read mux in front of NUM_SLAVES register banks.
module apb_slave_modport
  import apb_pkg::*;
#(
  parameter int NUM_SLAVES  = APB_NUM_SEL,
  parameter int DEPTH       = 16,
  parameter int WAIT_STATES = 0
) (
  input  logic                CLK,
  input  logic                PRESET,
  apb_slave_modport_if.slave  bus
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam int CNT_W = 4;

  apb_phase_e             w_phase;
  logic                   w_ready;
  logic                   w_onehot;
  logic [IDX_W-1:0]       w_idx;
  logic [APB_DATA_W-1:0]  w_rdata;
  logic [APB_DATA_W-1:0]  w_bank_rdata [NUM_SLAVES];
  logic [CNT_W-1:0]       r_cnt;
  logic                   w_unused_addr;

  // NOTE: every signal driven in always_comb gets a default first so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    w_phase = IDLE;
    if (bus.PSEL != '0) w_phase = bus.PENABLE ? ACCESS : SETUP;
  end

  // Outputs are forced low while reset is held, even mid-access.
  assign w_ready  = !PRESET && (w_phase == ACCESS) && (r_cnt == CNT_W'(WAIT_STATES));
  assign w_onehot = $onehot(bus.PSEL);
  assign w_idx    = bus.PADDR[2 +: IDX_W];

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of process ordering.
  always_ff @(posedge CLK) begin
    if (PRESET || (w_phase != ACCESS) || w_ready) r_cnt <= '0;
    else                                          r_cnt <= r_cnt + 4'd1;
  end

  for (genvar g = 0; g < NUM_SLAVES; g++) begin : g_bank
    apb_reg_bank #(.DEPTH(DEPTH)) u_bank (
      .CLK     (CLK),
      .PRESET  (PRESET),
      .i_we    (w_ready && w_onehot && bus.PWRITE && bus.PSEL[g]),
      .i_idx   (w_idx),
      .i_wdata (bus.PWDATA),
      .o_rdata (w_bank_rdata[g])
    );
  end

  always_comb begin
    w_rdata = '0;
    if (!PRESET && (w_phase == ACCESS) && !bus.PWRITE && w_onehot) begin
      for (int i = 0; i < NUM_SLAVES; i++) begin
        if (bus.PSEL[i]) w_rdata = w_bank_rdata[i];
      end
    end
  end

  assign bus.PRDATA = w_rdata;
  assign bus.PREADY = w_ready;

  // Byte-lane and high address bits are deliberately ignored.
  assign w_unused_addr = ^bus.PADDR;

endmodule

// File: tb/tb_apb_slave_modport.sv
// Directed bench for apb_slave_modport: two instances (0 and 2 wait states)
// checked every cycle against a transaction-level memory model.
module tb_apb_slave_modport;

  logic        clk = 1'b0;
  logic [1:0]  preset = 2'b11;
  int          dsel = 0;
  logic [3:0]  psel = '0;
  logic        penable = 1'b0;
  logic        pwrite = 1'b0;
  logic [31:0] paddr = '0;
  logic [31:0] pwdata = '0;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  apb_slave_modport_if if0 ();
  apb_slave_modport_if if1 ();

  assign if0.PSEL    = (dsel == 0) ? psel : 4'b0000;
  assign if0.PENABLE = penable;
  assign if0.PWRITE  = pwrite;
  assign if0.PADDR   = paddr;
  assign if0.PWDATA  = pwdata;
  assign if1.PSEL    = (dsel == 1) ? psel : 4'b0000;
  assign if1.PENABLE = penable;
  assign if1.PWRITE  = pwrite;
  assign if1.PADDR   = paddr;
  assign if1.PWDATA  = pwdata;

  apb_slave_modport #(.NUM_SLAVES(4), .DEPTH(16), .WAIT_STATES(0)) u_dut0 (
    .CLK(clk), .PRESET(preset[0]), .bus(if0.slave)
  );
  apb_slave_modport #(.NUM_SLAVES(4), .DEPTH(16), .WAIT_STATES(2)) u_dut1 (
    .CLK(clk), .PRESET(preset[1]), .bus(if1.slave)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [31:0] m_mem [2][4][16];
  int          m_acc [2] = '{0, 0};   // access cycles already spent in the current transfer
  int          m_ws  [2] = '{0, 2};

  function automatic logic [3:0] sel_of(input int d);
    return (dsel == d) ? psel : 4'b0000;
  endfunction

  function automatic bit m_access(input int d);
    return (sel_of(d) != 0) && penable;
  endfunction

  function automatic bit m_ready(input int d);
    return !preset[d] && m_access(d) && (m_acc[d] == m_ws[d]);
  endfunction

  function automatic int bank_of(input logic [3:0] s);
    int b = 0;
    for (int i = 0; i < 4; i++) if (s[i]) b = i;
    return b;
  endfunction

  function automatic logic [31:0] m_rdata(input int d);
    logic [3:0] s = sel_of(d);
    if (preset[d] || !m_access(d) || pwrite || $countones(s) != 1) return 32'h0;
    return m_mem[d][bank_of(s)][(paddr >> 2) % 16];
  endfunction

  always @(posedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (preset[d]) begin
        for (int b = 0; b < 4; b++) for (int w = 0; w < 16; w++) m_mem[d][b][w] = 32'h0;
        m_acc[d] = 0;
      end else if (!m_access(d)) begin
        m_acc[d] = 0;
      end else if (m_ready(d)) begin
        if (pwrite && $countones(sel_of(d)) == 1)
          m_mem[d][bank_of(sel_of(d))][(paddr >> 2) % 16] = pwdata;
        m_acc[d] = 0;
      end else begin
        m_acc[d] = m_acc[d] + 1;
      end
    end
  end

  always @(negedge clk) begin
    check("d0_pready", {31'b0, if0.PREADY}, {31'b0, m_ready(0)});
    check("d0_prdata", if0.PRDATA, m_rdata(0));
    check("d1_pready", {31'b0, if1.PREADY}, {31'b0, m_ready(1)});
    check("d1_prdata", if1.PRDATA, m_rdata(1));
  end

  // ---------------- stimulus ----------------
  function automatic logic dut_ready(input int d);
    return (d == 0) ? if0.PREADY : if1.PREADY;
  endfunction

  function automatic logic [31:0] dut_rdata(input int d);
    return (d == 0) ? if0.PRDATA : if1.PRDATA;
  endfunction

  // Leaves the bus in its last access state so the next call is back-to-back.
  task automatic xfer(input int d, input logic [3:0] sel, input logic [31:0] addr,
                      input logic wr, input logic [31:0] data,
                      output logic [31:0] rdata, output int nacc);
    bit done = 0;
    dsel = d; psel = sel; paddr = addr; pwrite = wr; pwdata = data; penable = 1'b0;
    rdata = '0; nacc = 0;
    @(posedge clk); #1;
    penable = 1'b1;
    for (int i = 0; i < 32 && !done; i++) begin
      @(negedge clk);
      nacc++;
      if (dut_ready(d)) begin
        rdata = dut_rdata(d);
        done = 1;
      end
      @(posedge clk); #1;
    end
    if (!done) check("pready_timeout", 32'h0, 32'h1);
  endtask

  task automatic go_idle();
    psel = '0; penable = 1'b0; pwrite = 1'b0;
    @(posedge clk); #1;
  endtask

  logic [31:0] rd;
  int          n;
  logic [31:0] bank_vals [4] = '{32'h1111_1111, 32'h2222_2222, 32'h3333_3333, 32'h4444_4444};

  initial begin
    repeat (2) @(posedge clk);
    #1 preset = 2'b00;

    // Every word of every bank reads zero after reset, single access cycle.
    for (int b = 0; b < 4; b++) begin
      for (int w = 0; w < 16; w++) begin
        xfer(0, 4'b0001 << b, w * 4, 1'b0, 32'h0, rd, n);
        check("reset_rd", rd, 32'h0);
        check("reset_nacc", n, 1);
      end
    end
    go_idle();

    // Basic write then back-to-back read; other bank stays zero.
    xfer(0, 4'b0001, 32'h04, 1'b1, 32'hDEAD_BEEF, rd, n);
    check("wr_nacc", n, 1);
    xfer(0, 4'b0001, 32'h04, 1'b0, 32'h0, rd, n);
    check("basic_rd", rd, 32'hDEAD_BEEF);
    xfer(0, 4'b0010, 32'h04, 1'b0, 32'h0, rd, n);
    check("other_bank_rd", rd, 32'h0);

    // Bank isolation at the same address.
    for (int b = 0; b < 4; b++) xfer(0, 4'b0001 << b, 32'h08, 1'b1, bank_vals[b], rd, n);
    for (int b = 0; b < 4; b++) begin
      xfer(0, 4'b0001 << b, 32'h08, 1'b0, 32'h0, rd, n);
      check("iso_rd", rd, bank_vals[b]);
    end

    // Address wraps modulo DEPTH words; byte lanes ignored.
    xfer(0, 4'b0100, 32'h40, 1'b1, 32'hA5A5_A5A5, rd, n);
    xfer(0, 4'b0100, 32'h00, 1'b0, 32'h0, rd, n);
    check("wrap_rd", rd, 32'hA5A5_A5A5);
    xfer(0, 4'b0100, 32'h0000_1003, 1'b0, 32'h0, rd, n);
    check("wrap_hi_rd", rd, 32'hA5A5_A5A5);

    // Multi-bit select: still completes, writes nothing.
    xfer(0, 4'b0011, 32'h0C, 1'b1, 32'hFFFF_FFFF, rd, n);
    check("inv_nacc", n, 1);
    xfer(0, 4'b0001, 32'h0C, 1'b0, 32'h0, rd, n);
    check("inv_rd_b0", rd, 32'h0);
    xfer(0, 4'b0010, 32'h0C, 1'b0, 32'h0, rd, n);
    check("inv_rd_b1", rd, 32'h0);
    go_idle();

    // Two wait states: 3 access cycles per transfer.
    xfer(1, 4'b0001, 32'h10, 1'b1, 32'h1234_5678, rd, n);
    check("ws2_wr_nacc", n, 3);
    xfer(1, 4'b0001, 32'h10, 1'b0, 32'h0, rd, n);
    check("ws2_rd", rd, 32'h1234_5678);
    check("ws2_rd_nacc", n, 3);
    go_idle();

    // Reset in the 2nd access cycle aborts the write.
    dsel = 1; psel = 4'b0010; paddr = 32'h14; pwrite = 1'b1; pwdata = 32'hCAFE_F00D;
    @(posedge clk); #1 penable = 1'b1;
    @(posedge clk); #1 preset[1] = 1'b1;
    @(posedge clk); #1 preset[1] = 1'b0;
    go_idle();
    xfer(1, 4'b0010, 32'h14, 1'b0, 32'h0, rd, n);
    check("abort_rd", rd, 32'h0);
    xfer(1, 4'b0001, 32'h10, 1'b0, 32'h0, rd, n);
    check("abort_clr_rd", rd, 32'h0);
    go_idle();
    repeat (3) @(posedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
